// File: rtl/psum_tile_buffer.sv
// Circular buffer for one tile's strategy-1 results, replayed as last-tile partial sums
// with a one-cycle accumulation strobe; first-tile reads supply zeros without popping.
module psum_tile_buffer #(
   parameter int LANES = 16,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_wr_en,
   input  logic [LANES*32-1:0]   i_wr_data,
   input  logic                  i_rd_en,
   input  logic                  i_first_tile,
   output logic [LANES*32-1:0]   o_psum,
   output logic                  o_accumulation,
   output logic [CW-1:0]         o_count,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = LANES * 32;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic [DW-1:0] r_psum;
   logic          r_accumulation;
   logic          r_full;
   logic          r_empty;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_pop;
   logic          w_first;
   logic          w_under;
   logic          w_wr_ok;
   logic          w_wr_drop;

   assign w_pop     = i_rd_en && !i_first_tile && !r_empty;
   assign w_first   = i_rd_en && i_first_tile;
   assign w_under   = i_rd_en && !i_first_tile && r_empty;
   // A pop frees a slot in the same cycle, so a write on full is accepted alongside it.
   assign w_wr_ok   = i_wr_en && (!r_full || w_pop);
   assign w_wr_drop = i_wr_en && r_full && !w_pop;

   always_comb begin
      w_count_next = r_count;
      if (w_wr_ok && !w_pop)
         w_count_next = r_count + CW'(1);
      else if (!w_wr_ok && w_pop)
         w_count_next = r_count - CW'(1);
   end

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_clr && w_wr_ok)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_psum         <= '0;
         r_accumulation <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else if (i_clr) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_psum         <= '0;
         r_accumulation <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_pop)
            r_psum <= r_mem[r_rd_ptr];
         else if (w_first)
            r_psum <= '0;
         r_accumulation <= w_pop || w_first;
         r_count        <= w_count_next;
         r_full         <= (w_count_next == CW'(DEPTH));
         r_empty        <= (w_count_next == '0);
         if (w_wr_drop)
            r_overflow <= 1'b1;
         if (w_under)
            r_underflow <= 1'b1;
      end
   end

   assign o_psum         = r_psum;
   assign o_accumulation = r_accumulation;
   assign o_count        = r_count;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_psum_tile_buffer.sv
// Directed self-checking bench for psum_tile_buffer (LANES=16, DEPTH=8).
module tb_psum_tile_buffer;

   localparam int LANES = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int DW    = LANES * 32;

   logic            i_clk;
   logic            i_rst_n;
   logic            i_clr;
   logic            i_wr_en;
   logic [DW-1:0]   i_wr_data;
   logic            i_rd_en;
   logic            i_first_tile;
   logic [DW-1:0]   o_psum;
   logic            o_accumulation;
   logic [CW-1:0]   o_count;
   logic            o_full;
   logic            o_empty;
   logic            o_overflow;
   logic            o_underflow;

   int checks = 0;
   int errors = 0;

   psum_tile_buffer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_clr          (i_clr),
      .i_wr_en        (i_wr_en),
      .i_wr_data      (i_wr_data),
      .i_rd_en        (i_rd_en),
      .i_first_tile   (i_first_tile),
      .o_psum         (o_psum),
      .o_accumulation (o_accumulation),
      .o_count        (o_count),
      .o_full         (o_full),
      .o_empty        (o_empty),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int base);
      logic [DW-1:0] v;
      for (int k = 0; k < LANES; k++)
         v[32*k +: 32] = 32'(base + k);
      return v;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_wr_en      = 1'b0;
      i_rd_en      = 1'b0;
      i_first_tile = 1'b0;
      i_clr        = 1'b0;
   endtask

   initial begin
      i_rst_n   = 1'b0;
      i_wr_data = '0;
      idle();
      tick();
      tick();
      chk("rst_psum",  o_psum, '0);
      chk("rst_acc",   o_accumulation, 0);
      chk("rst_count", o_count, 0);
      chk("rst_full",  o_full, 0);
      chk("rst_empty", o_empty, 1);
      chk("rst_ovf",   o_overflow, 0);
      chk("rst_udf",   o_underflow, 0);
      i_rst_n = 1'b1;
      tick();

      // three writes, three back-to-back reads
      for (int n = 0; n < 3; n++) begin
         i_wr_en = 1'b1; i_wr_data = mk(100 * n);
         tick();
      end
      idle();
      chk("t1_count", o_count, 3);
      chk("t1_empty", o_empty, 0);
      i_rd_en = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("t1_acc",   o_accumulation, 1);
         chk("t1_lane5", o_psum[32*5 +: 32], 32'(100 * n + 5));
         chk("t1_psum",  o_psum, mk(100 * n));
      end
      idle();
      chk("t1_count0", o_count, 0);
      chk("t1_empty1", o_empty, 1);
      tick();
      chk("t1_acc_off", o_accumulation, 0);
      chk("t1_hold",    o_psum[32*5 +: 32], 205);

      // first-tile read with two entries stored
      i_wr_en = 1'b1; i_wr_data = mk(1000); tick();
      i_wr_data = mk(2000); tick();
      idle();
      i_rd_en = 1'b1; i_first_tile = 1'b1;
      tick();
      idle();
      chk("t2_psum0", o_psum, '0);
      chk("t2_acc",   o_accumulation, 1);
      chk("t2_count", o_count, 2);
      i_rd_en = 1'b1;
      tick();
      chk("t2_rd0", o_psum, mk(1000));
      tick();
      chk("t2_rd1", o_psum, mk(2000));
      idle();
      chk("t2_empty", o_empty, 1);

      // fill, overflow, simultaneous write+read on full
      i_wr_en = 1'b1;
      for (int n = 0; n < DEPTH; n++) begin
         i_wr_data = mk(3000 + 10 * n);
         tick();
      end
      chk("t3_full",  o_full, 1);
      chk("t3_count", o_count, 8);
      chk("t3_ovf0",  o_overflow, 0);
      i_wr_data = mk(9999);
      tick();
      chk("t3_ovf",    o_overflow, 1);
      chk("t3_count9", o_count, 8);
      chk("t3_full9",  o_full, 1);
      i_wr_data = mk(7000); i_rd_en = 1'b1;
      tick();
      idle();
      chk("t3_wr_rd_acc",   o_accumulation, 1);
      chk("t3_wr_rd_data",  o_psum, mk(3000));
      chk("t3_wr_rd_count", o_count, 8);
      chk("t3_wr_rd_full",  o_full, 1);
      i_rd_en = 1'b1;
      for (int n = 1; n < DEPTH; n++) begin
         tick();
         chk("t3_drain", o_psum, mk(3000 + 10 * n));
      end
      tick();
      idle();
      chk("t3_drain_new", o_psum, mk(7000));
      chk("t3_empty",     o_empty, 1);
      chk("t3_ovf_stky",  o_overflow, 1);
      i_clr = 1'b1; tick(); idle();
      chk("t3_clr_ovf", o_overflow, 0);

      // underflow on empty, then write+read together on empty
      i_rd_en = 1'b1;
      tick();
      chk("t4_udf",  o_underflow, 1);
      chk("t4_acc",  o_accumulation, 0);
      chk("t4_hold", o_psum, '0);
      i_wr_en = 1'b1; i_wr_data = mk(8000);
      tick();
      idle();
      chk("t4_udf_stky", o_underflow, 1);
      chk("t4_count",    o_count, 1);
      chk("t4_acc_none", o_accumulation, 0);
      i_clr = 1'b1; tick(); idle();
      chk("t4_clr_udf",   o_underflow, 0);
      chk("t4_clr_count", o_count, 0);

      // 20 entries streamed through with occupancy 1..2, wrapping the pointers
      for (int c = 0; c < 22; c++) begin
         i_wr_en   = (c < 20);
         i_wr_data = mk(c);
         i_rd_en   = (c >= 2);
         tick();
         if (c >= 2) begin
            chk("t5_acc",   o_accumulation, 1);
            chk("t5_lane0", o_psum[31:0], 32'(c - 2));
         end
      end
      idle();
      chk("t5_ovf",   o_overflow, 0);
      chk("t5_udf",   o_underflow, 0);
      chk("t5_empty", o_empty, 1);

      // flush with i_clr
      i_wr_en = 1'b1;
      for (int n = 0; n < 5; n++) begin
         i_wr_data = mk(400 + n);
         tick();
      end
      idle();
      chk("t6_count5", o_count, 5);
      i_clr = 1'b1; tick(); idle();
      chk("t6_count", o_count, 0);
      chk("t6_empty", o_empty, 1);
      chk("t6_full",  o_full, 0);
      chk("t6_psum",  o_psum, '0);

      // asynchronous reset during a strobe
      i_wr_en = 1'b1; i_wr_data = mk(500); tick(); idle();
      i_rd_en = 1'b1; tick(); idle();
      chk("t6_pre_acc",  o_accumulation, 1);
      chk("t6_pre_psum", o_psum, mk(500));
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("t6_rst_acc",   o_accumulation, 0);
      chk("t6_rst_psum",  o_psum, '0);
      chk("t6_rst_empty", o_empty, 1);
      tick();
      i_rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
